spr_window_gen: RTL and testbench

Front-end window builder for the subpixel-rendering core. It accepts the incoming R and B sample streams four samples per clock and carries the last sample of each group across to the next. It then emits the 5-sample-per-channel window that the SPR core consumes, together with the line-position and row-parity control it needs: first-pixel flag, odd/even row flag, and frame-shadowed enable and separate-case mode. It sits directly upstream of the SPR core and also checks that each line has the expected length.

---
 rtl/spr_window_gen.sv | 160 ++++++++++++++++
 tb/tb_spr_window_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spr_window_gen.sv
// spr_window_gen: builds the 5-sample R/B window and the line/frame control
// for the subpixel-rendering core from a 4-sample-per-clock input stream.
module spr_window_gen #(
  parameter int DW = 12,
  parameter int GW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_vs,
  input  logic            i_hs,
  input  logic            i_de,
  input  logic [4*DW-1:0] i_data_r,
  input  logic [4*DW-1:0] i_data_b,
  input  logic            cfg_en,
  input  logic            cfg_spr_seperate_case,
  input  logic [GW-1:0]   cfg_h_groups,
  output logic            o_vs,
  output logic            o_hs,
  output logic            o_de,
  output logic [5*DW-1:0] spr_core_in_r,
  output logic [5*DW-1:0] spr_core_in_b,
  output logic            is_first_pixel,
  output logic            odd_even_flag,
  output logic            en,
  output logic            spr_seperate_case,
  output logic [GW-1:0]   o_grp_cnt,
  output logic            o_line_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_LINE
  } state_t;

  localparam logic [GW-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic [DW-1:0]   hold_r_q, hold_r_d;
  logic [DW-1:0]   hold_b_q, hold_b_d;
  logic [GW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   hg_q, hg_d;
  logic            en_q, en_d;
  logic            sep_q, sep_d;
  logic            vs_q, vs_d;
  logic            hs_q, hs_d;
  logic            de_q, de_d;
  logic            first_q, first_d;
  logic            par_q, par_d;
  logic            err_q, err_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [5*DW-1:0] win_r_q, win_r_d;
  logic [5*DW-1:0] win_b_q, win_b_d;

  logic          first;
  logic [DW-1:0] p_r, p_b;

  // A group arriving while in S_BLANK is by construction an i_de rise.
  assign first = (state_q == S_BLANK);
  assign p_r   = first ? i_data_r[DW-1:0] : hold_r_q;
  assign p_b   = first ? i_data_b[DW-1:0] : hold_b_q;

  always_comb begin
    state_d  = state_q;
    hold_r_d = hold_r_q;
    hold_b_d = hold_b_q;
    cnt_d    = cnt_q;
    hg_d     = hg_q;
    en_d     = en_q;
    sep_d    = sep_q;
    vs_d     = i_vs;
    hs_d     = i_hs;
    de_d     = 1'b0;
    first_d  = 1'b0;
    par_d    = par_q;
    err_d    = err_q;
    grp_d    = grp_q;
    win_r_d  = win_r_q;
    win_b_d  = win_b_q;
    if (i_vs) begin
      state_d = S_BLANK;
      hg_d    = cfg_h_groups;
      en_d    = cfg_en;
      sep_d   = cfg_spr_seperate_case;
      par_d   = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else if (i_de && state_q != S_IDLE) begin
      state_d  = S_LINE;
      de_d     = 1'b1;
      first_d  = first;
      hold_r_d = i_data_r[4*DW-1:3*DW];
      hold_b_d = i_data_b[4*DW-1:3*DW];
      win_r_d  = {i_data_r, p_r};
      win_b_d  = {i_data_b, p_b};
      if (first) begin
        grp_d = '0;
        cnt_d = GW'(1);
      end else begin
        grp_d = cnt_q;
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + GW'(1);
      end
    end else if (!i_de && state_q == S_LINE) begin
      state_d = S_BLANK;
      par_d   = ~par_q;
      if (cnt_q != hg_q) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hold_r_q <= '0;
      hold_b_q <= '0;
      cnt_q    <= '0;
      hg_q     <= '0;
      en_q     <= 1'b0;
      sep_q    <= 1'b0;
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      de_q     <= 1'b0;
      first_q  <= 1'b0;
      par_q    <= 1'b0;
      err_q    <= 1'b0;
      grp_q    <= '0;
      win_r_q  <= '0;
      win_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_r_q <= hold_r_d;
      hold_b_q <= hold_b_d;
      cnt_q    <= cnt_d;
      hg_q     <= hg_d;
      en_q     <= en_d;
      sep_q    <= sep_d;
      vs_q     <= vs_d;
      hs_q     <= hs_d;
      de_q     <= de_d;
      first_q  <= first_d;
      par_q    <= par_d;
      err_q    <= err_d;
      grp_q    <= grp_d;
      win_r_q  <= win_r_d;
      win_b_q  <= win_b_d;
    end
  end

  assign o_vs              = vs_q;
  assign o_hs              = hs_q;
  assign o_de              = de_q;
  assign spr_core_in_r     = win_r_q;
  assign spr_core_in_b     = win_b_q;
  assign is_first_pixel    = first_q;
  assign odd_even_flag     = par_q;
  assign en                = en_q;
  assign spr_seperate_case = sep_q;
  assign o_grp_cnt         = grp_q;
  assign o_line_err        = err_q;

endmodule

// File: tb/tb_spr_window_gen.sv
// tb_spr_window_gen: vector table, directed corner sequences and a
// randomized run against a behavioural model of the window builder.
module tb_spr_window_gen;
  localparam int DW = 12;
  localparam int GW = 10;
  localparam int CMAX = (1 << GW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;
  logic [4*DW-1:0] i_data_r = '0, i_data_b = '0;
  logic            cfg_en = 1'b0, cfg_sep = 1'b0;
  logic [GW-1:0]   cfg_h = '0;
  logic            o_vs, o_hs, o_de, first, par, en, sep, lerr;
  logic [5*DW-1:0] win_r, win_b;
  logic [GW-1:0]   grp;

  int checks = 0;
  int failures = 0;

  spr_window_gen #(.DW(DW), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .i_data_r(i_data_r), .i_data_b(i_data_b),
    .cfg_en(cfg_en), .cfg_spr_seperate_case(cfg_sep),
    .cfg_h_groups(cfg_h),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
    .spr_core_in_r(win_r), .spr_core_in_b(win_b),
    .is_first_pixel(first), .odd_even_flag(par),
    .en(en), .spr_seperate_case(sep),
    .o_grp_cnt(grp), .o_line_err(lerr)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*DW-1:0] grp4(int b);
    return {DW'(b + 3), DW'(b + 2), DW'(b + 1), DW'(b)};
  endfunction

  function automatic logic [5*DW-1:0] mk5(int a0, int a1, int a2, int a3, int a4);
    return {DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  typedef struct {
    bit vs; bit de; int d0; bit en_in;
    bit e_de; bit e_first; int e_grp; bit e_err; bit e_par; bit e_en;
    int w0; int w1; int w2; int w3; int w4;
  } vec_t;

  function automatic vec_t row(bit vs, bit de, int d0, bit en_in,
      bit e_de, bit e_first, int e_grp, bit e_err, bit e_par, bit e_en,
      int w0, int w1, int w2, int w3, int w4);
    vec_t v;
    v.vs = vs; v.de = de; v.d0 = d0; v.en_in = en_in;
    v.e_de = e_de; v.e_first = e_first; v.e_grp = e_grp;
    v.e_err = e_err; v.e_par = e_par; v.e_en = e_en;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3; v.w4 = w4;
    return v;
  endfunction

  task automatic drive(bit vs, bit de, int d0);
    i_vs = vs;
    i_de = de;
    i_data_r = grp4(d0);
    i_data_b = grp4(d0 + 100);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_de"}, o_de, 0);
    chk({tag, "_vs"}, o_vs, 0);
    chk({tag, "_winr"}, win_r, 0);
    chk({tag, "_winb"}, win_b, 0);
    chk({tag, "_first"}, first, 0);
    chk({tag, "_par"}, par, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_grp"}, grp, 0);
    chk({tag, "_err"}, lerr, 0);
  endtask

  // Behavioural model state
  bit m_armed, m_inl, m_err, m_sen, m_ssep;
  int m_cnt, m_lines, m_sh;
  logic [DW-1:0] m_hr, m_hb;
  bit e_vs, e_hs, e_de, e_first;
  int e_grp;
  logic [5*DW-1:0] e_wr, e_wb;

  task automatic model_reset();
    m_armed = 0; m_inl = 0; m_err = 0; m_sen = 0; m_ssep = 0;
    m_cnt = 0; m_lines = 0; m_sh = 0; m_hr = '0; m_hb = '0;
    e_vs = 0; e_hs = 0; e_de = 0; e_first = 0; e_grp = 0;
    e_wr = '0; e_wb = '0;
  endtask

  task automatic model_step();
    int c;
    e_vs = i_vs;
    e_hs = i_hs;
    e_de = 0;
    e_first = 0;
    c = (m_cnt > CMAX) ? CMAX : m_cnt;
    if (i_vs) begin
      m_armed = 1; m_inl = 0; m_cnt = 0; m_lines = 0; m_err = 0;
      m_sen = cfg_en; m_ssep = cfg_sep; m_sh = int'(cfg_h);
    end else if (m_armed && i_de) begin
      e_de = 1;
      e_first = !m_inl;
      e_grp = m_inl ? c : 0;
      m_cnt = m_inl ? m_cnt + 1 : 1;
      e_wr = {i_data_r, m_inl ? m_hr : i_data_r[DW-1:0]};
      e_wb = {i_data_b, m_inl ? m_hb : i_data_b[DW-1:0]};
      m_hr = i_data_r[4*DW-1:3*DW];
      m_hb = i_data_b[4*DW-1:3*DW];
      m_inl = 1;
    end else if (m_armed && m_inl) begin
      m_lines++;
      if (c != m_sh) m_err = 1;
      m_inl = 0;
    end
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = row(1, 0, 0, 1,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    tbl[1]  = row(0, 1, 1, 1,  1, 1, 0, 0, 0, 1,  1, 1, 2, 3, 4);
    tbl[2]  = row(0, 1, 5, 1,  1, 0, 1, 0, 0, 1,  4, 5, 6, 7, 8);
    tbl[3]  = row(0, 1, 9, 1,  1, 0, 2, 0, 0, 1,  8, 9, 10, 11, 12);
    tbl[4]  = row(0, 0, 0, 1,  0, 0, 2, 0, 1, 1,  8, 9, 10, 11, 12);
    tbl[5]  = row(0, 1, 20, 0, 1, 1, 0, 0, 1, 1,  20, 20, 21, 22, 23);
    tbl[6]  = row(0, 1, 24, 0, 1, 0, 1, 0, 1, 1,  23, 24, 25, 26, 27);
    tbl[7]  = row(0, 0, 0, 0,  0, 0, 1, 1, 0, 1,  23, 24, 25, 26, 27);
    tbl[8]  = row(0, 1, 30, 0, 1, 1, 0, 1, 0, 1,  30, 30, 31, 32, 33);
    tbl[9]  = row(0, 1, 34, 0, 1, 0, 1, 1, 0, 1,  33, 34, 35, 36, 37);
    tbl[10] = row(0, 1, 38, 0, 1, 0, 2, 1, 0, 1,  37, 38, 39, 40, 41);
    tbl[11] = row(0, 0, 0, 0,  0, 0, 2, 1, 1, 1,  37, 38, 39, 40, 41);
    tbl[12] = row(1, 0, 0, 0,  0, 0, 2, 0, 0, 0,  37, 38, 39, 40, 41);

    // Reset state, then a burst with no frame start
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("reset");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 200 + 4 * i);
      tick();
      chk("idle_de", o_de, 0);
    end

    // Table: one good line, a short line, a good line, new frame
    cfg_sep = 1'b1;
    cfg_h = GW'(3);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].vs, tbl[i].de, tbl[i].d0);
      cfg_en = tbl[i].en_in;
      i_hs = ~tbl[i].de;
      tick();
      chk($sformatf("t%0d_vs", i), o_vs, tbl[i].vs);
      chk($sformatf("t%0d_hs", i), o_hs, !tbl[i].de);
      chk($sformatf("t%0d_de", i), o_de, tbl[i].e_de);
      chk($sformatf("t%0d_first", i), first, tbl[i].e_first);
      chk($sformatf("t%0d_grp", i), grp, tbl[i].e_grp);
      chk($sformatf("t%0d_err", i), lerr, tbl[i].e_err);
      chk($sformatf("t%0d_par", i), par, tbl[i].e_par);
      chk($sformatf("t%0d_en", i), en, tbl[i].e_en);
      chk($sformatf("t%0d_sep", i), sep, 1);
      chk($sformatf("t%0d_winr", i), win_r,
          mk5(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3, tbl[i].w4));
      chk($sformatf("t%0d_winb", i), win_b, (i == 0) ? '0 :
          mk5(tbl[i].w0 + 100, tbl[i].w1 + 100, tbl[i].w2 + 100,
              tbl[i].w3 + 100, tbl[i].w4 + 100));
    end
    i_hs = 1'b0;

    // Frame start colliding with a group mid-line
    drive(1, 0, 0);
    tick();
    drive(0, 1, 50);
    tick();
    chk("col_first0", first, 1);
    drive(0, 1, 54);
    tick();
    drive(1, 1, 58);
    tick();
    chk("col_de", o_de, 0);
    chk("col_err", lerr, 0);
    chk("col_first", first, 0);
    drive(0, 1, 62);
    tick();
    chk("col_rise_de", o_de, 1);
    chk("col_rise_first", first, 1);
    chk("col_rise_grp", grp, 0);
    chk("col_rise_win", win_r, mk5(62, 62, 63, 64, 65));
    drive(0, 0, 0);
    tick();

    // Asynchronous reset in the middle of a line
    drive(0, 1, 70);
    tick();
    chk("pre_rst_de", o_de, 1);
    drive(0, 1, 74);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 80 + 4 * i);
      tick();
      chk("post_rst_de", o_de, 0);
    end

    // Group counter saturation on an overlong line
    drive(1, 0, 0);
    tick();
    for (int i = 0; i < 1030; i++) begin
      drive(0, 1, i);
      tick();
      if (i == 5 || i == 1022 || i == 1023 || i == 1029)
        chk($sformatf("sat_grp%0d", i), grp, (i > CMAX) ? CMAX : i);
    end
    drive(0, 0, 0);
    tick();

    // Randomized run against the model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    begin
      bit de_r = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 3) == 0) de_r = ~de_r;
        i_de = de_r;
        i_vs = ($urandom_range(0, 49) == 0);
        i_hs = $urandom_range(0, 1);
        i_data_r = {$urandom, $urandom};
        i_data_b = {$urandom, $urandom};
        cfg_en = $urandom_range(0, 1);
        cfg_sep = $urandom_range(0, 1);
        cfg_h = GW'($urandom_range(2, 5));
        model_step();
        tick();
        chk("r_vs", o_vs, e_vs);
        chk("r_hs", o_hs, e_hs);
        chk("r_de", o_de, e_de);
        chk("r_first", first, e_first);
        chk("r_grp", grp, e_grp);
        chk("r_err", lerr, m_err);
        chk("r_par", par, m_lines % 2);
        chk("r_en", en, m_sen);
        chk("r_sep", sep, m_ssep);
        chk("r_winr", win_r, e_wr);
        chk("r_winb", win_b, e_wb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
